// File: rtl/rob_dual_commit.sv
// Reorder buffer with NCDB write-back ports, two in-order retire slots and flush-on-mispredict recovery.
// Optional macro ROB_BYPASS_EN: operand lookup also forwards same-cycle CDB results.
module rob_dual_commit #(
    parameter int WIDTH = 31,
    parameter int ROB   = 3,
    parameter int REG   = 4,
    parameter int NCDB  = 2
) (
    input  logic                       clk,
    input  logic                       globalReset,
    input  logic                       allocReq,
    input  logic [REG:0]               allocDest,
    input  logic                       allocRegWrite,
    output logic [ROB:0]               allocRob,
    output logic                       full,
    output logic                       empty,
    output logic [ROB+1:0]             count,
    input  logic [NCDB-1:0]            cdbValid,
    input  logic [NCDB*(ROB+1)-1:0]    cdbRob,
    input  logic [NCDB*(WIDTH+1)-1:0]  cdbResult,
    input  logic [NCDB-1:0]            cdbMispredict,
    input  logic [NCDB*(WIDTH+1)-1:0]  cdbTarget,
    input  logic [ROB:0]               rdRob1,
    input  logic [ROB:0]               rdRob2,
    output logic [WIDTH:0]             rdValue1,
    output logic [WIDTH:0]             rdValue2,
    output logic                       rdValid1,
    output logic                       rdValid2,
    output logic [1:0]                 commitValid,
    output logic [2*(ROB+1)-1:0]       commitRob,
    output logic [2*(REG+1)-1:0]       commitDest,
    output logic [2*(WIDTH+1)-1:0]     commitResult,
    output logic [1:0]                 commitRegWrite,
    output logic                       flush,
    output logic [WIDTH:0]             flushTarget
);
    localparam int DEPTH = 2 ** (ROB + 1);
    localparam logic [ROB+1:0] FULL_CNT = (ROB+2)'(DEPTH);

    logic           r_busy   [DEPTH];
    logic           r_done   [DEPTH];
    logic           r_misp   [DEPTH];
    logic           r_regw   [DEPTH];
    logic [REG:0]   r_dest   [DEPTH];
    logic [WIDTH:0] r_result [DEPTH];
    logic [WIDTH:0] r_target [DEPTH];
    logic [ROB:0]   r_head, r_tail;
    logic [ROB+1:0] r_count;
    logic           r_flush;
    logic [WIDTH:0] r_flushTarget;

    logic [ROB:0]   w_head1;
    logic           w_c0, w_c1, w_recover, w_allocOk;
    logic [ROB+1:0] w_nCommit;
    logic [ROB:0]   w_rdTag [2];
    logic [WIDTH:0] w_rdVal [2];
    logic           w_rdVld [2];

    assign w_head1   = r_head + 1'b1;
    assign full      = (r_count == FULL_CNT);
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign allocRob  = r_tail;
    assign w_c0      = r_busy[r_head] && r_done[r_head];
    // A mispredicted head blocks slot 1: everything younger is wrong-path.
    assign w_c1      = w_c0 && r_busy[w_head1] && r_done[w_head1] && !r_misp[r_head];
    assign w_recover = w_c0 && r_misp[r_head];
    assign w_allocOk = allocReq && !full;
    assign w_nCommit = {{ROB{1'b0}}, w_c0 & w_c1, w_c0 ^ w_c1};

    assign commitValid = {w_c1, w_c0};
    assign flush       = r_flush;
    assign flushTarget = r_flushTarget;

    always_comb begin
        commitRob      = '0;
        commitDest     = '0;
        commitResult   = '0;
        commitRegWrite = '0;
        if (w_c0) begin
            commitRob[0 +: ROB+1]      = r_head;
            commitDest[0 +: REG+1]     = r_dest[r_head];
            commitResult[0 +: WIDTH+1] = r_result[r_head];
            commitRegWrite[0]          = r_regw[r_head];
        end
        if (w_c1) begin
            commitRob[ROB+1 +: ROB+1]        = w_head1;
            commitDest[REG+1 +: REG+1]       = r_dest[w_head1];
            commitResult[WIDTH+1 +: WIDTH+1] = r_result[w_head1];
            commitRegWrite[1]                = r_regw[w_head1];
        end
    end

    assign w_rdTag[0] = rdRob1;
    assign w_rdTag[1] = rdRob2;
    assign rdValid1   = w_rdVld[0];
    assign rdValid2   = w_rdVld[1];
    assign rdValue1   = w_rdVal[0];
    assign rdValue2   = w_rdVal[1];

    always_comb begin
        for (int k = 0; k < 2; k++) begin
            w_rdVld[k] = r_busy[w_rdTag[k]] && r_done[w_rdTag[k]];
            w_rdVal[k] = r_result[w_rdTag[k]];
`ifdef ROB_BYPASS_EN
            // Descending scan so the lowest-numbered matching port is the one that sticks.
            for (int i = NCDB - 1; i >= 0; i--) begin
                if (cdbValid[i] && cdbRob[i*(ROB+1) +: ROB+1] == w_rdTag[k] &&
                    r_busy[w_rdTag[k]] && !w_recover) begin
                    w_rdVld[k] = 1'b1;
                    w_rdVal[k] = cdbResult[i*(WIDTH+1) +: WIDTH+1];
                end
            end
`endif
        end
    end

    always_ff @(posedge clk or posedge globalReset) begin
        if (globalReset) begin
            for (int e = 0; e < DEPTH; e++) begin
                r_busy[e]   <= 1'b0;
                r_done[e]   <= 1'b0;
                r_misp[e]   <= 1'b0;
                r_regw[e]   <= 1'b0;
                r_dest[e]   <= '0;
                r_result[e] <= '0;
                r_target[e] <= '0;
            end
            r_head        <= '0;
            r_tail        <= '0;
            r_count       <= '0;
            r_flush       <= 1'b0;
            r_flushTarget <= '0;
        end else begin
            // Later (lower-index) assignments override, giving port 0 priority on tag collisions.
            for (int i = NCDB - 1; i >= 0; i--) begin
                if (cdbValid[i] && r_busy[cdbRob[i*(ROB+1) +: ROB+1]]) begin
                    r_done[cdbRob[i*(ROB+1) +: ROB+1]]   <= 1'b1;
                    r_result[cdbRob[i*(ROB+1) +: ROB+1]] <= cdbResult[i*(WIDTH+1) +: WIDTH+1];
                    r_misp[cdbRob[i*(ROB+1) +: ROB+1]]   <= cdbMispredict[i];
                    r_target[cdbRob[i*(ROB+1) +: ROB+1]] <= cdbTarget[i*(WIDTH+1) +: WIDTH+1];
                end
            end
            if (w_c0) begin
                r_busy[r_head]   <= 1'b0;
                r_done[r_head]   <= 1'b0;
                r_misp[r_head]   <= 1'b0;
                r_regw[r_head]   <= 1'b0;
                r_dest[r_head]   <= '0;
                r_result[r_head] <= '0;
                r_target[r_head] <= '0;
            end
            if (w_c1) begin
                r_busy[w_head1]   <= 1'b0;
                r_done[w_head1]   <= 1'b0;
                r_misp[w_head1]   <= 1'b0;
                r_regw[w_head1]   <= 1'b0;
                r_dest[w_head1]   <= '0;
                r_result[w_head1] <= '0;
                r_target[w_head1] <= '0;
            end
            r_flush       <= w_recover;
            r_flushTarget <= w_recover ? r_target[r_head] : '0;
            if (w_recover) begin
                for (int e = 0; e < DEPTH; e++) begin
                    r_busy[e]   <= 1'b0;
                    r_done[e]   <= 1'b0;
                    r_misp[e]   <= 1'b0;
                    r_regw[e]   <= 1'b0;
                    r_dest[e]   <= '0;
                    r_result[e] <= '0;
                    r_target[e] <= '0;
                end
                r_head  <= w_head1;
                r_tail  <= w_head1;
                r_count <= '0;
            end else begin
                if (w_allocOk) begin
                    r_busy[r_tail]   <= 1'b1;
                    r_done[r_tail]   <= 1'b0;
                    r_misp[r_tail]   <= 1'b0;
                    r_regw[r_tail]   <= allocRegWrite;
                    r_dest[r_tail]   <= allocDest;
                    r_result[r_tail] <= '0;
                    r_target[r_tail] <= '0;
                    r_tail           <= r_tail + 1'b1;
                end
                r_head  <= r_head + w_nCommit[ROB:0];
                r_count <= r_count + (ROB+2)'(w_allocOk) - w_nCommit;
            end
        end
    end
endmodule
